// File: rtl/sterownik_obrazu_procesu_pkg.sv
// Shared definitions for the PLC process-image controller: FSM states,
// image address map and image size.
package sterownik_obrazu_procesu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_UPDATE,
    ST_DONE
  } stan_t;

  localparam int unsigned IMG_IN_BASE  = 0;
  localparam int unsigned IMG_OUT_BASE = 8;
  localparam int unsigned BYTE_CNT     = 8;

  // addr[3] selects the output image; addr[2:0] is the byte within an image
  function automatic logic is_out_addr(input logic [3:0] addr);
    return addr >= 4'(IMG_OUT_BASE);
  endfunction

endpackage

// File: rtl/sterownik_obrazu_procesu_if.sv
// Byte-wide request/acknowledge CPU bus into the process image.
interface sterownik_obrazu_procesu_if;
  logic [3:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       err;

  modport master (output addr, rd, wr, wdata, input rdata, ack, err);
  modport slave  (input addr, rd, wr, wdata, output rdata, ack, err);
endinterface

// File: rtl/sterownik_obrazu_procesu_sync_wejsc.sv
// Reset-to-zero multi-stage synchronizer chain for asynchronous field inputs.
module sync_wejsc #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sterownik_obrazu_procesu.sv
// PLC process-image controller: scan FSM sampling inputs and driving outputs,
// CPU bus access to both images, and an output watchdog forcing the safe state.
module sterownik_obrazu_procesu
  import sterownik_obrazu_procesu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDT_CYCLES  = 1000000,
  parameter int unsigned WDT_W       = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [63:0]                 phys_in,
  output logic [63:0]                 phys_out,
  input  logic                        scan_req,
  output logic                        scan_busy,
  output logic                        scan_done,
  sterownik_obrazu_procesu_if.slave   bus,
  output logic                        wdt_trip
);

  localparam bit               WDT_EN   = (WDT_CYCLES != 0);
  localparam logic [WDT_W-1:0] WDT_LIM  = WDT_W'(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  stan_t                        state;
  logic [63:0]                  synced;
  logic [BYTE_CNT-1:0][7:0]     in_img;
  logic [BYTE_CNT-1:0][7:0]     out_img;
  logic [WDT_W-1:0]             wdt_cnt;

  sync_wejsc #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (64)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (phys_in),
    .q     (synced)
  );

  assign scan_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_img    <= '0;
      out_img   <= '0;
      phys_out  <= '0;
      scan_done <= 1'b0;
      wdt_trip  <= 1'b0;
      wdt_cnt   <= '0;
      bus.rdata <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;

      case (state)
        ST_IDLE: begin
          // scan wins over a same-cycle bus request; ack=1 blocks re-accepting a held request
          if (scan_req) begin
            state <= ST_SAMPLE;
          end else if ((bus.rd || bus.wr) && !bus.ack) begin
            bus.ack <= 1'b1;
            if (bus.wr) begin
              if (is_out_addr(bus.addr)) begin
                out_img[bus.addr[2:0]] <= bus.wdata;
              end else begin
                bus.err <= 1'b1;
              end
            end else if (is_out_addr(bus.addr)) begin
              bus.rdata <= out_img[bus.addr[2:0]];
            end else begin
              bus.rdata <= in_img[bus.addr[2:0]];
            end
          end
        end
        ST_SAMPLE: begin
          in_img <= synced;
          state  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          phys_out  <= out_img;
          scan_done <= 1'b1;
          state     <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // trip asserts together with the counter reaching the limit, then holds until UPDATE
      if (state == ST_UPDATE) begin
        wdt_cnt  <= '0;
        wdt_trip <= 1'b0;
      end else if (WDT_EN) begin
        if (wdt_cnt < WDT_LIM) begin
          wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
        if (wdt_cnt >= WDT_LAST) begin
          wdt_trip <= 1'b1;
          phys_out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sterownik_obrazu_procesu.sv
// Scoreboarded bench for the process-image controller: bus accesses queue their
// expected responses, which a monitor retires whenever ack appears.
module tb_sterownik_obrazu_procesu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] phys_in;
  logic [63:0] phys_out, phys_out0;
  logic        scan_req;
  logic        scan_busy, scan_done, wdt_trip;
  logic        busy0, done0, trip0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] in_m  [8];
  logic [7:0] out_m [8];

  always #5 clk = ~clk;

  sterownik_obrazu_procesu_if bus ();
  sterownik_obrazu_procesu_if bus0 ();

  assign bus0.addr  = bus.addr;
  assign bus0.rd    = bus.rd;
  assign bus0.wr    = bus.wr;
  assign bus0.wdata = bus.wdata;

  sterownik_obrazu_procesu #(
    .SYNC_STAGES (2),
    .WDT_CYCLES  (16),
    .WDT_W       (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phys_in   (phys_in),
    .phys_out  (phys_out),
    .scan_req  (scan_req),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .bus       (bus.slave),
    .wdt_trip  (wdt_trip)
  );

  sterownik_obrazu_procesu #(
    .SYNC_STAGES (2),
    .WDT_CYCLES  (0),
    .WDT_W       (5)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .phys_in   (phys_in),
    .phys_out  (phys_out0),
    .scan_req  (scan_req),
    .scan_busy (busy0),
    .scan_done (done0),
    .bus       (bus0.slave),
    .wdt_trip  (trip0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = out_m[i];
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.ack) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", {63'd0, bus.ack}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, {56'd0, bus.rdata}, {56'd0, e.rdata});
        chk({e.tag, "_err"}, {63'd0, bus.err}, {63'd0, e.err});
      end
    end
  end

  function automatic exp_t predict(input bit r, input bit w, input int a,
                                   input logic [7:0] d, input string tag);
    exp_t e;
    e.tag = tag;
    e.rdata = 8'h00;
    e.err = 1'b0;
    if (w) begin
      if (a < 8) e.err = 1'b1;
      else out_m[a-8] = d;
    end else if (r) begin
      e.rdata = (a < 8) ? in_m[a] : out_m[a-8];
    end
    return e;
  endfunction

  // called at a negedge; returns at a negedge with the bus idle again
  task automatic bus_op(input bit r, input bit w, input int a, input logic [7:0] d,
                        input string tag);
    int n;
    sb.push_back(predict(r, w, a, d, tag));
    bus.addr = 4'(a);
    bus.rd = r;
    bus.wr = w;
    bus.wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 20);
    chk({tag, "_lat"}, 64'(n), 64'd1);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic scan(input logic [63:0] exp_out, input string tag);
    scan_req = 1'b1;
    @(negedge clk);
    scan_req = 1'b0;
    chk({tag, "_busy1"}, {63'd0, scan_busy}, 64'd1);
    @(negedge clk);
    chk({tag, "_busy2"}, {63'd0, scan_busy}, 64'd1);
    chk({tag, "_done_early"}, {63'd0, scan_done}, 64'd0);
    @(negedge clk);
    chk({tag, "_busy3"}, {63'd0, scan_busy}, 64'd1);
    chk({tag, "_done"}, {63'd0, scan_done}, 64'd1);
    chk({tag, "_phys_out"}, phys_out, exp_out);
    chk({tag, "_trip"}, {63'd0, wdt_trip}, 64'd0);
    @(negedge clk);
    chk({tag, "_idle"}, {63'd0, scan_busy}, 64'd0);
    chk({tag, "_done_end"}, {63'd0, scan_done}, 64'd0);
    for (int i = 0; i < 8; i++) in_m[i] = phys_in[8*i +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    scan_req = 1'b0;
    phys_in = '0;
    bus.addr = '0;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.wdata = '0;
    for (int i = 0; i < 8; i++) begin
      in_m[i] = 8'h00;
      out_m[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_phys_out", phys_out, 64'd0);
    chk("rst_busy", {63'd0, scan_busy}, 64'd0);
    chk("rst_done", {63'd0, scan_done}, 64'd0);
    chk("rst_trip", {63'd0, wdt_trip}, 64'd0);
    chk("rst_ack", {62'd0, bus.ack, bus.err}, 64'd0);
    chk("rst_rdata", {56'd0, bus.rdata}, 64'd0);
    rst_n = 1'b1;

    // basic scan and input readback
    phys_in = 64'h0807060504030201;
    repeat (4) @(negedge clk);
    scan(64'd0, "scan1");
    for (int a = 0; a < 8; a++) bus_op(1'b1, 1'b0, a, 8'h00, $sformatf("rd_in%0d", a));

    // output path
    bus_op(1'b0, 1'b1, 8, 8'hA5, "wr8");
    bus_op(1'b0, 1'b1, 15, 8'h3C, "wr15");
    chk("out_hold", phys_out, 64'd0);
    scan(64'h3C000000000000A5, "scan2");
    chk("scan2_word", out_word(), 64'h3C000000000000A5);
    bus_op(1'b1, 1'b0, 8, 8'h00, "rd8");
    bus_op(1'b1, 1'b0, 15, 8'h00, "rd15");

    // illegal write and rd+wr collision
    bus_op(1'b0, 1'b1, 2, 8'h77, "wr_ill");
    bus_op(1'b1, 1'b0, 2, 8'h00, "rd2_after_ill");
    bus_op(1'b1, 1'b1, 9, 8'h11, "rdwr9");
    bus_op(1'b1, 1'b0, 9, 8'h00, "rd9");

    // bus request stalled behind a same-cycle scan
    phys_in = 64'hF0E0D0C0B0A09080;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) in_m[i] = phys_in[8*i +: 8];
    sb.push_back(predict(1'b1, 1'b0, 0, 8'h00, "stall_rd0"));
    scan_req = 1'b1;
    bus.addr = 4'd0;
    bus.rd = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      scan_req = 1'b0;
      n++;
    end while (!bus.ack && n < 20);
    chk("stall_lat", 64'(n), 64'd5);
    bus.rd = 1'b0;
    @(negedge clk);

    // watchdog
    for (int a = 8; a < 16; a++) bus_op(1'b0, 1'b1, a, 8'hFF, $sformatf("wr_ff%0d", a));
    scan({64{1'b1}}, "scan_wdt");
    repeat (14) @(negedge clk);
    chk("wdt_pre_trip", {63'd0, wdt_trip}, 64'd0);
    chk("wdt_pre_out", phys_out, {64{1'b1}});
    @(negedge clk);
    chk("wdt_trip", {63'd0, wdt_trip}, 64'd1);
    chk("wdt_out_safe", phys_out, 64'd0);
    repeat (30) @(negedge clk);
    chk("wdt_hold_trip", {63'd0, wdt_trip}, 64'd1);
    chk("wdt_hold_out", phys_out, 64'd0);
    chk("wdt0_trip", {63'd0, trip0}, 64'd0);
    chk("wdt0_out", phys_out0, {64{1'b1}});
    bus_op(1'b1, 1'b0, 15, 8'h00, "rd15_tripped");
    scan({64{1'b1}}, "scan_recover");

    // reset in the middle of a scan
    scan_req = 1'b1;
    @(negedge clk);
    scan_req = 1'b0;
    chk("mid_in_sample", {63'd0, scan_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_phys_out", phys_out, 64'd0);
    chk("mid_busy", {63'd0, scan_busy}, 64'd0);
    chk("mid_done", {63'd0, scan_done}, 64'd0);
    chk("mid_trip", {63'd0, wdt_trip}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      in_m[i] = 8'h00;
      out_m[i] = 8'h00;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_no_done", {63'd0, scan_done}, 64'd0);
    for (int a = 8; a < 16; a++) bus_op(1'b1, 1'b0, a, 8'h00, $sformatf("rd_rst%0d", a));
    bus_op(1'b0, 1'b1, 12, 8'h5A, "wr12");
    scan(64'h0000005A00000000, "scan_after_rst");
    bus_op(1'b1, 1'b0, 0, 8'h00, "rd0_after_rst");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sterownik_obrazu_procesu.md
Name: sterownik_obrazu_procesu

Overview:
CPU-side controller for the PLC process image, sitting between the processor data bus and the field I/O. It samples eight physical input bytes into an input image on each scan. It holds an eight-byte output image written by the CPU and drives it to the physical outputs on each scan. It also provides a byte-wide request/acknowledge bus port, a scan handshake, and an output watchdog that forces the safe state when scans stop.

Parameters:
SYNC_STAGES, 2, synchronizer flops on phys_in (allowed values 2..4)
WDT_CYCLES, 1000000, clk cycles without a completed scan before outputs go safe; 0 disables the watchdog
WDT_W, 20, watchdog counter width; must satisfy 2**WDT_W > WDT_CYCLES

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
phys_in  in  64  field inputs; byte k = bits [8k+7:8k]; asynchronous to clk
phys_out  out  64  registered field outputs, same byte layout
scan_req  in  1  one-cycle pulse: start a scan
scan_busy  out  1  high whenever the FSM is not in IDLE
scan_done  out  1  one-cycle pulse when a scan completes
addr  in  4  0-7 = input image byte (read-only); 8-15 = output image byte (read/write)
rd  in  1  read request, level; held until ack
wr  in  1  write request, level; held until ack
wdata  in  8  write data
rdata  out  8  read data; valid in the cycle ack is high
ack  out  1  one-cycle acknowledge
err  out  1  valid with ack: 1 = write to addr 0-7 (write ignored)
wdt_trip  out  1  high while outputs are forced safe by the watchdog

Behaviour:
- Reset (rst_n=0, asynchronous): the following all clear to 0 and the FSM goes to IDLE.
  - in_img, out_img, sync flops
  - phys_out, rdata, ack, err, scan_done, wdt_trip
  - watchdog counter
- Input sync: phys_in passes through SYNC_STAGES flops continuously. in_img only ever loads the last stage.
- FSM states: IDLE, SAMPLE, UPDATE, DONE.
  - IDLE -> SAMPLE when scan_req=1.
  - SAMPLE: in_img <= synced inputs. Next state UPDATE.
  - UPDATE: phys_out <= out_img; wdt_trip <= 0; watchdog counter <= 0. Next state DONE.
  - DONE: scan_done=1 for this cycle only. Next state IDLE.
  - Latency: scan_req at edge t gives in_img valid after t+1, phys_out after t+2, scan_done high during cycle t+3, IDLE at t+4.
- scan_req while not in IDLE: ignored, no queuing.
- Bus: requests are accepted only in IDLE, with ack=0, and with scan_req=0. Scan has priority over a bus request in the same cycle.
  - Accepted access: ack=1 on the next cycle with rdata/err valid. Latency is 1 when not stalled.
  - A request pending during a scan stalls until IDLE. The master drops rd/wr in the cycle it sees ack.
  - A request present in the ack cycle is not accepted again; accept requires ack=0.
- Read, addr 0-7: returns in_img[addr]. Read, addr 8-15: returns out_img[addr-8]. err=0 for all reads.
- Write, addr 8-15: out_img[addr-8] <= wdata. phys_out is unchanged until the next UPDATE.
- Write, addr 0-7: no state change; ack with err=1.
- rd and wr both high: treated as a write; rdata=0.
- Watchdog (WDT_CYCLES>0):
  - The counter increments every cycle outside UPDATE and saturates at WDT_CYCLES.
  - On reaching WDT_CYCLES: phys_out <= 0 and wdt_trip <= 1.
  - Both are held until the next UPDATE. out_img is preserved.
  - The watchdog counter counts during a stalled or idle scan FSM.
- Reset mid-scan: immediate return to IDLE, no scan_done, all outputs cleared.

Decomposition:
- Shared header (included `define/localparam file): FSM state encodings, address map constants (IMG_IN_BASE=0, IMG_OUT_BASE=8), byte count 8.
- One sub-module: sync_wejsc, a parameterized SYNC_STAGES-deep, 64-bit, reset-to-0 flop chain, instantiated once for phys_in.

Test Plan:
- Reset then scan: phys_in=64'h0807060504030201; wait >SYNC_STAGES cycles; pulse scan_req.
  - Expect scan_busy for 3 cycles and scan_done at t+3.
  - Reads of addr 0-7 return 01..08 in order, each with ack one cycle after request, err=0.
- Output path: write A5 to addr 8 and 3C to addr 15.
  - phys_out stays 0 until the next scan.
  - After the scan, phys_out=64'h3C000000000000A5. Readback of 8 and 15 returns A5 and 3C.
- Illegal and collision cases:
  - Write 77 to addr 2: ack with err=1, in_img[2] unchanged.
  - rd+wr together at addr 9 with wdata=11: out_img[1]=11, rdata=0.
- Stall: assert rd at addr 0 in the same cycle as scan_req.
  - Scan proceeds first; ack arrives in the first IDLE cycle after DONE.
  - rdata equals the newly sampled in_img[0].
- Watchdog with WDT_CYCLES=16:
  - After a scan with out_img=FF..FF, run no scans: after 16 cycles phys_out=0 and wdt_trip=1.
  - Next scan: wdt_trip=0 and phys_out=FF..FF.
  - Repeat with WDT_CYCLES=0: no trip.
- Reset mid-scan: drop rst_n in SAMPLE.
  - Immediately: phys_out=0, scan_busy=0, no scan_done, reads of addr 8-15 return 0.
  - A new scan after rst_n release works normally.
